serial_subbit: RTL and testbench

Bit-serial subtractor: computes diff = a - b - bi over WIDTH cycles, LSB first, with a single full-subtractor cell and a borrow flip-flop. It is the inverse-direction companion to the team's 1-bit full adder cell (a, b, ci -> sum, co). It is used where area matters more than latency, and provides a start/busy/done handshake to its controller.

---
 rtl/serial_subbit.sv | 136 +++++++++++++
 tb/tb_serial_subbit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subbit.sv
// serial_subbit: bit-serial subtractor, diff = a - b - bi, LSB first.
// One full-subtractor cell plus a borrow flip-flop processes one bit per
// cycle. A start/busy/done handshake frames each WIDTH-cycle operation.
// diff and bo are result registers that only change when an operation
// completes (or on reset), so they stay valid while the next one runs.

module serial_subbit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bo
);

    // Counter only has to reach WIDTH-1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] a_r, a_s;
    logic [WIDTH-1:0] b_r, b_s;
    logic [WIDTH-2:0] part_r, part_s;
    logic [WIDTH-1:0] diff_r, diff_s;
    logic             br_r, br_s;
    logic             bo_r, bo_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [1:0]       cell_s;
    logic [WIDTH-1:0] shifted_s;

    // Full-subtractor cell: returns {borrow_out, difference_bit}.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
        logic d;
        logic bout;
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
        full_sub = {bout, d};
    endfunction

    // Cell evaluation on the current LSBs and the partial result with the new bit shifted in.
    always_comb begin
        cell_s    = full_sub(a_r[0], b_r[0], br_r);
        shifted_s = {cell_s[0], part_r};
    end

    // Next-state and datapath update decode.
    always_comb begin
        state_s = state_r;
        a_s     = a_r;
        b_s     = b_r;
        part_s  = part_r;
        diff_s  = diff_r;
        br_s    = br_r;
        bo_s    = bo_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    a_s     = a;
                    b_s     = b;
                    br_s    = bi;
                    part_s  = {(WIDTH-1){1'b0}};
                    cnt_s   = CNT_ZERO;
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                a_s    = {1'b0, a_r[WIDTH-1:1]};
                b_s    = {1'b0, b_r[WIDTH-1:1]};
                br_s   = cell_s[1];
                part_s = shifted_s[WIDTH-1:1];
                if (cnt_r == CNT_LAST) begin
                    // Last bit: the shifted register now holds the full result.
                    diff_s  = shifted_s;
                    bo_s    = cell_s[1];
                    cnt_s   = CNT_ZERO;
                    state_s = DONE;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                    state_s = RUN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            part_r  <= {(WIDTH-1){1'b0}};
            diff_r  <= {WIDTH{1'b0}};
            br_r    <= 1'b0;
            bo_r    <= 1'b0;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            a_r     <= a_s;
            b_r     <= b_s;
            part_r  <= part_s;
            diff_r  <= diff_s;
            br_r    <= br_s;
            bo_r    <= bo_s;
            cnt_r   <= cnt_s;
        end
    end

    assign busy = (state_r != IDLE);
    assign done = (state_r == DONE);
    assign diff = diff_r;
    assign bo   = bo_r;

endmodule

// File: tb/tb_serial_subbit.sv
// Bench for serial_subbit: an 8-bit and a 4-bit instance, each checked every
// cycle against a countdown-style behavioural model that computes the result
// with plain (WIDTH+1)-bit arithmetic, plus literal expectations.

module tb_serial_subbit;

    localparam int W8 = 8;
    localparam int W4 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic          start8 = 1'b0;
    logic [W8-1:0] a8 = '0;
    logic [W8-1:0] b8 = '0;
    logic          bi8 = 1'b0;
    logic          busy8, done8, bo8;
    logic [W8-1:0] diff8;

    logic          start4 = 1'b0;
    logic [W4-1:0] a4 = '0;
    logic [W4-1:0] b4 = '0;
    logic          bi4 = 1'b0;
    logic          busy4, done4, bo4;
    logic [W4-1:0] diff4;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;
    int done_cnt8 = 0;
    int done_cnt4 = 0;

    // Model state: cycles of busy remaining, pending result, visible result.
    int            rem8 = 0;
    logic [W8:0]   res8 = '0;
    logic [W8-1:0] ed8 = '0;
    logic          eb8 = 1'b0;
    int            rem4 = 0;
    logic [W4:0]   res4 = '0;
    logic [W4-1:0] ed4 = '0;
    logic          eb4 = 1'b0;

    serial_subbit #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bi(bi8),
        .busy(busy8), .done(done8), .diff(diff8), .bo(bo8)
    );

    serial_subbit #(.WIDTH(W4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bi(bi4),
        .busy(busy4), .done(done4), .diff(diff4), .bo(bo4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model, 8-bit instance.
    always @(posedge clk) begin
        if (!rst_n) begin
            rem8 <= 0;
            ed8  <= '0;
            eb8  <= 1'b0;
        end else if (rem8 == 0) begin
            if (start8) begin
                rem8 <= W8 + 1;
                res8 <= {1'b0, a8} - {1'b0, b8} - {{W8{1'b0}}, bi8};
            end
        end else begin
            rem8 <= rem8 - 1;
            if (rem8 == 2) begin
                ed8 <= res8[W8-1:0];
                eb8 <= res8[W8];
            end
        end
    end

    // Behavioural model, 4-bit instance.
    always @(posedge clk) begin
        if (!rst_n) begin
            rem4 <= 0;
            ed4  <= '0;
            eb4  <= 1'b0;
        end else if (rem4 == 0) begin
            if (start4) begin
                rem4 <= W4 + 1;
                res4 <= {1'b0, a4} - {1'b0, b4} - {{W4{1'b0}}, bi4};
            end
        end else begin
            rem4 <= rem4 - 1;
            if (rem4 == 2) begin
                ed4 <= res4[W4-1:0];
                eb4 <= res4[W4];
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy8", 64'(busy8), 64'(rem8 != 0));
            check("done8", 64'(done8), 64'(rem8 == 1));
            check("diff8", 64'(diff8), 64'(ed8));
            check("bo8",   64'(bo8),   64'(eb8));
            check("busy4", 64'(busy4), 64'(rem4 != 0));
            check("done4", 64'(done4), 64'(rem4 == 1));
            check("diff4", 64'(diff4), 64'(ed4));
            check("bo4",   64'(bo4),   64'(eb4));
            if (done8 === 1'b1) done_cnt8++;
            if (done4 === 1'b1) done_cnt4++;
        end
    end

    // Wait (bounded) for done8, returning the number of negedges waited.
    task automatic wait_done8(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL timeout8: no done within 40 cycles at t=%0t", $time);
        end
    endtask

    // One 8-bit operation with literal expected result and latency.
    task automatic op8(input string nm, input logic [7:0] av, input logic [7:0] bv,
                       input logic biv, input logic [7:0] edv, input logic ebv);
        int lat;
        @(negedge clk);
        start8 = 1'b1; a8 = av; b8 = bv; bi8 = biv;
        @(negedge clk);
        check({nm, "_busy_first"}, 64'(busy8), 64'd1);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
        wait_done8(lat);
        check({nm, "_lat"},  64'(lat),   64'd8);
        check({nm, "_diff"}, 64'(diff8), 64'(edv));
        check({nm, "_bo"},   64'(bo8),   64'(ebv));
        @(negedge clk);
        check({nm, "_idle"}, 64'(busy8), 64'd0);
    endtask

    int ord[512];
    int lat;
    int d0;

    initial begin
        // Reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_done8", 64'(done8), 64'd0);
        check("rst_diff8", 64'(diff8), 64'd0);
        check("rst_bo8",   64'(bo8),   64'd0);
        check("rst_busy4", 64'(busy4), 64'd0);
        rst_n = 1'b1;

        // Basic, underflow, equality and max values.
        op8("basic",  8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
        op8("under1", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
        op8("under2", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        op8("eq",     8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
        op8("maxbi",  8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0);
        op8("msb",    8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);

        // Start held high while busy.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h01; bi8 = 1'b0;
        @(negedge clk);
        a8 = 8'h00; b8 = 8'h01;
        #1 d0 = done_cnt8;
        wait_done8(lat);
        check("hold_lat1",  64'(lat),   64'd8);
        check("hold_diff1", 64'(diff8), 64'h0F);
        check("hold_bo1",   64'(bo8),   64'd0);
        @(negedge clk);
        check("hold_idle", 64'(busy8), 64'd0);
        #1 check("hold_one_done", 64'(done_cnt8), 64'(d0 + 1));
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(lat);
        check("hold_lat2",  64'(lat),   64'd8);
        check("hold_diff2", 64'(diff8), 64'hFF);
        check("hold_bo2",   64'(bo8),   64'd1);
        @(negedge clk);

        // Reset in the middle of RUN.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'h33; bi8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy8), 64'd0);
        check("abort_done", 64'(done8), 64'd0);
        check("abort_diff", 64'(diff8), 64'd0);
        check("abort_bo",   64'(bo8),   64'd0);
        rst_n = 1'b1;
        #1 d0 = done_cnt8;
        repeat (12) @(negedge clk);
        #1 check("abort_no_done", 64'(done_cnt8), 64'(d0));
        op8("restart", 8'h22, 8'h11, 1'b0, 8'h11, 1'b0);

        // Random starts and operands on the 8-bit instance.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            start8 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
        end
        @(negedge clk);
        start8 = 1'b0;
        repeat (12) @(negedge clk);

        // All 512 operand combinations on the 4-bit instance, shuffled, back to back.
        for (int i = 0; i < 512; i++) ord[i] = i;
        for (int i = 511; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(0, i));
            t = ord[i]; ord[i] = ord[j]; ord[j] = t;
        end
        #1 d0 = done_cnt4;
        for (int k = 0; k < 512; k++) begin
            logic [8:0] v;
            logic [4:0] ex;
            v = ord[k][8:0];
            @(negedge clk);
            start4 = 1'b1; a4 = v[3:0]; b4 = v[7:4]; bi4 = v[8];
            ex = {1'b0, v[3:0]} - {1'b0, v[7:4]} - {4'b0000, v[8]};
            @(negedge clk);
            start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); bi4 = 1'($urandom);
            repeat (W4) @(negedge clk);
            check("x4_done",   64'(done4),        64'd1);
            check("x4_result", 64'({bo4, diff4}), 64'(ex));
        end
        @(negedge clk);
        #1 check("x4_done_count", 64'(done_cnt4), 64'(d0 + 512));

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
